// File: rtl/video_pkg.sv
// video_pkg: shared definitions for the display path.
//   vmode_e       colour mode encoding (value 3 is decoded as mono)
//   SP_*          default Specialist raster timing
//   addr_w()      counter / address field width for a count of n values
package video_pkg;

    typedef enum logic [1:0] {
        VM_MONO = 2'd0,
        VM_FG8  = 2'd1,
        VM_FG16 = 2'd2
    } vmode_e;

    localparam int SP_H_TOTAL  = 512;
    localparam int SP_H_ACTIVE = 384;
    localparam int SP_HS_START = 415;
    localparam int SP_HS_END   = 463;
    localparam int SP_V_TOTAL  = 312;
    localparam int SP_V_ACTIVE = 256;
    localparam int SP_VS_START = 271;
    localparam int SP_VS_END   = 281;
    localparam int SP_RD_LAT   = 1;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_raster_if.sv
// video_raster_if: fixed-latency video RAM read port.
//   vram_rd    read strobe, one clk wide
//   vram_addr  {column, row}
//   vram_q     {attr[7:0], bitmap[7:0]}, valid RD_LAT ce ticks after the strobe
// master = raster engine, slave = memory.
interface video_raster_if import video_pkg::*; #(
    parameter int ADDR_W = addr_w(SP_H_ACTIVE / 8) + addr_w(SP_V_ACTIVE)
);
    logic              vram_rd;
    logic [ADDR_W-1:0] vram_addr;
    logic [15:0]       vram_q;

    modport master (output vram_rd, vram_addr, input vram_q);
    modport slave  (input vram_rd, vram_addr, output vram_q);
endinterface

// File: rtl/video_timing.sv
// video_timing: raster counters and raw timing.
//   clk_pix, reset, ce_pix  clock, async active-high reset, pixel enable
//   hc, vc                  horizontal / vertical position
//   hs_raw, vs_raw          syncs for the previous ce tick's position (registered)
//   active                  current position lies in the visible area
//   frame_start             high on the ce tick where hc and vc both wrap
module video_timing import video_pkg::*; #(
    parameter int H_TOTAL  = SP_H_TOTAL,
    parameter int H_ACTIVE = SP_H_ACTIVE,
    parameter int HS_START = SP_HS_START,
    parameter int HS_END   = SP_HS_END,
    parameter int V_TOTAL  = SP_V_TOTAL,
    parameter int V_ACTIVE = SP_V_ACTIVE,
    parameter int VS_START = SP_VS_START,
    parameter int VS_END   = SP_VS_END,
    localparam int HC_W    = addr_w(H_TOTAL),
    localparam int VC_W    = addr_w(V_TOTAL)
) (
    input  logic            clk_pix,
    input  logic            reset,
    input  logic            ce_pix,
    output logic [HC_W-1:0] hc,
    output logic [VC_W-1:0] vc,
    output logic            hs_raw,
    output logic            vs_raw,
    output logic            active,
    output logic            frame_start
);
    localparam logic [HC_W-1:0] HT_M1 = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] HA    = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] HSS   = HC_W'(HS_START);
    localparam logic [HC_W-1:0] HSE   = HC_W'(HS_END);
    localparam logic [VC_W-1:0] VT_M1 = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] VA    = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] VSS   = VC_W'(VS_START);
    localparam logic [VC_W-1:0] VSE   = VC_W'(VS_END);

    logic h_wrap, v_wrap;

    assign h_wrap      = (hc == HT_M1);
    assign v_wrap      = (vc == VT_M1);
    assign active      = (hc < HA) && (vc < VA);
    assign frame_start = ce_pix && h_wrap && v_wrap;

    always_ff @(posedge clk_pix or posedge reset) begin
        if (reset) begin
            hc     <= '0;
            vc     <= '0;
            hs_raw <= 1'b0;
            vs_raw <= 1'b0;
        end else if (ce_pix) begin
            hs_raw <= (hc >= HSS) && (hc < HSE);
            vs_raw <= (vc >= VSS) && (vc < VSE);
            if (h_wrap) begin
                hc <= '0;
                vc <= v_wrap ? '0 : vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end
        end
    end
endmodule

// File: rtl/video_raster.sv
// video_raster: raster engine. Fetches one {attr, bitmap} word per 8-pixel
// column, serialises it to 6:6:6 RGB and delays syncs to match.
//   clk_pix, reset, ce_pix  clock, async active-high reset, pixel enable
//   mode                    0 mono, 1 FG8, 2 FG16, 3 mono
//   vram                    read port (master side)
//   r, g, b, de, hs, vs     pixel output, all aligned
//   frame_start             ce tick where the raster wraps to (0,0)
// Pixel x of a line leaves the output register one clk after the ce tick
// with hc = x+9: fetch at column start, capture within the column, load the
// shifter at the next column start, then one output register.
module video_raster import video_pkg::*; #(
    parameter int H_TOTAL  = SP_H_TOTAL,
    parameter int H_ACTIVE = SP_H_ACTIVE,
    parameter int HS_START = SP_HS_START,
    parameter int HS_END   = SP_HS_END,
    parameter int V_TOTAL  = SP_V_TOTAL,
    parameter int V_ACTIVE = SP_V_ACTIVE,
    parameter int VS_START = SP_VS_START,
    parameter int VS_END   = SP_VS_END,
    parameter int RD_LAT   = SP_RD_LAT
) (
    input  logic       clk_pix,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic [1:0] mode,
    video_raster_if.master vram,
    output logic [5:0] r,
    output logic [5:0] g,
    output logic [5:0] b,
    output logic       hs,
    output logic       vs,
    output logic       de,
    output logic       frame_start
);
    localparam int HC_W  = addr_w(H_TOTAL);
    localparam int VC_W  = addr_w(V_TOTAL);
    localparam int COL_W = addr_w(H_ACTIVE / 8);
    localparam int ROW_W = addr_w(V_ACTIVE);

    logic [HC_W-1:0] hc;
    logic [VC_W-1:0] vc;
    logic            hs_raw, vs_raw, active;

    video_timing #(
        .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE), .HS_START(HS_START), .HS_END(HS_END),
        .V_TOTAL(V_TOTAL), .V_ACTIVE(V_ACTIVE), .VS_START(VS_START), .VS_END(VS_END)
    ) u_timing (
        .clk_pix(clk_pix), .reset(reset), .ce_pix(ce_pix),
        .hc(hc), .vc(vc), .hs_raw(hs_raw), .vs_raw(vs_raw),
        .active(active), .frame_start(frame_start)
    );

    logic col_start, fetch;
    assign col_start = (hc[2:0] == 3'd0);
    assign fetch     = active && col_start;

    // Strobe is combinational so it sits exactly on the ce tick it belongs to.
    assign vram.vram_rd   = ce_pix && !reset && fetch;
    assign vram.vram_addr = {COL_W'(hc >> 3), ROW_W'(vc)};

    logic [RD_LAT-1:0] rd_sr;      // bit k: a strobe was issued k+1 ce ticks ago
    logic [15:0]       fbuf;
    logic              fbuf_vld;   // cleared by each load, so a missed refill blanks
    logic [1:0]        mode_f;     // mode sampled with the fetch of the buffered column
    logic [7:0]        attr, bmp;
    logic              sh_act;
    logic [1:0]        sh_mode;
    logic [8:1]        hs_d, vs_d;
    logic [17:0]       rgb;
    logic              p;

    assign p = bmp[7];

    always_comb begin
        rgb = {18{p}};
        case (sh_mode)
            VM_FG8:  rgb = {{6{p & attr[6]}}, {6{p & attr[5]}}, {6{p & attr[4]}}};
            VM_FG16: rgb = p ? {{2{attr[6]}}, {4{attr[7]}}, {2{attr[5]}}, {4{attr[7]}},
                                {2{attr[4]}}, {4{attr[7]}}}
                             : {{2{attr[2]}}, {4{attr[3]}}, {2{attr[1]}}, {4{attr[3]}},
                                {2{attr[0]}}, {4{attr[3]}}};
            default: rgb = {18{p}};
        endcase
    end

    always_ff @(posedge clk_pix or posedge reset) begin
        if (reset) begin
            rd_sr    <= '0;
            fbuf     <= '0;
            fbuf_vld <= 1'b0;
            mode_f   <= '0;
            attr     <= '0;
            bmp      <= '0;
            sh_act   <= 1'b0;
            sh_mode  <= '0;
            hs_d     <= '0;
            vs_d     <= '0;
            r        <= '0;
            g        <= '0;
            b        <= '0;
            hs       <= 1'b0;
            vs       <= 1'b0;
            de       <= 1'b0;
        end else if (ce_pix) begin
            rd_sr <= (rd_sr << 1) | RD_LAT'(fetch);
            if (fetch)
                mode_f <= mode;
            // RD_LAT <= 7 keeps capture strictly inside the column, never on a load tick.
            if (rd_sr[RD_LAT-1]) begin
                fbuf     <= vram.vram_q;
                fbuf_vld <= 1'b1;
            end else if (col_start) begin
                fbuf_vld <= 1'b0;
            end
            if (col_start) begin
                {attr, bmp} <= fbuf;
                sh_act      <= fbuf_vld;
                sh_mode     <= mode_f;
            end else begin
                bmp <= {bmp[6:0], 1'b0};
            end
            hs_d <= {hs_d[7:1], hs_raw};
            vs_d <= {vs_d[7:1], vs_raw};
            hs   <= hs_d[8];
            vs   <= vs_d[8];
            de   <= sh_act;
            {r, g, b} <= sh_act ? rgb : 18'd0;
        end
    end
endmodule

// File: tb/tb_video_raster.sv
// tb_video_raster: directed checks on a reduced raster (64x20 total,
// 32x12 visible, RD_LAT=3) so whole frames fit in a short run.
// Pixel x of a line is visible at the negedge where hc (ticks into the line) = x+10.
module tb_video_raster;
    import video_pkg::*;

    localparam int HT = 64, HA = 32, HSS = 40, HSE = 48;
    localparam int VT = 20, VA = 12, VSS = 14, VSE = 16;
    localparam int LAT = 3, AW = 6;

    logic       clk_pix = 1'b0;
    logic       reset   = 1'b1;
    logic       ce_pix  = 1'b1;
    logic [1:0] mode    = 2'd0;
    logic [5:0] r, g, b;
    logic       hs, vs, de, frame_start;

    logic [15:0]   mem   [0:(1<<AW)-1];
    logic [AW-1:0] apipe [0:LAT-1];
    logic [7:0]    pat = 8'hA5;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int tick, hs_cnt, vs_cnt, fs_cnt, st5, stv;

    video_raster_if #(.ADDR_W(AW)) vram_bus ();

    video_raster #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .HS_START(HSS), .HS_END(HSE),
        .V_TOTAL(VT), .V_ACTIVE(VA), .VS_START(VSS), .VS_END(VSE), .RD_LAT(LAT)
    ) dut (
        .clk_pix(clk_pix), .reset(reset), .ce_pix(ce_pix), .mode(mode),
        .vram(vram_bus),
        .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .de(de), .frame_start(frame_start)
    );

    always #5 clk_pix = ~clk_pix;

    // Memory model: address travels LAT ce ticks, then data is presented.
    always @(posedge clk_pix)
        if (ce_pix) begin
            apipe[0] <= vram_bus.vram_addr;
            for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
        end
    assign vram_bus.vram_q = mem[apipe[LAT-1]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd"}, vram_bus.vram_rd, 0);
        chk({tag, "_addr"}, vram_bus.vram_addr, 0);
        chk({tag, "_r"}, r, 0);
        chk({tag, "_g"}, g, 0);
        chk({tag, "_b"}, b, 0);
        chk({tag, "_hs"}, hs, 0);
        chk({tag, "_vs"}, vs, 0);
        chk({tag, "_de"}, de, 0);
        chk({tag, "_fs"}, frame_start, 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;
        mem[0]  = 16'h00A5;   // line 0 col 0: mono pattern
        mem[48] = 16'h0001;   // line 0 col 3: last visible pixel lit
        mem[1]  = 16'h00FF;   // line 1 col 0
        mem[17] = 16'h00FF;   // line 1 col 1, attr 0
        mem[2]  = 16'hCBF0;   // line 2 col 0: fg intensity bit 7 and bg intensity bit 3 set
        mem[3]  = 16'h50AA;   // line 3 col 0: FG8 red+blue
        mem[4]  = 16'hFF80;   // line 4 col 0: mode 3 must ignore attr
        mem[21] = 16'h00FF;   // line 5 col 1
        hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; st5 = 0; stv = 0;

        // Reset state with ce held high.
        repeat (3) @(negedge clk_pix);
        #1 chk_zero("rst");
        @(negedge clk_pix);
        reset = 1'b0;

        // Free run, ce=1: n = ce ticks completed = hc + 64*vc.
        for (int n = 0; n < 2 * HT * VT; n++) begin
            #1;
            if (n < HT && hs) hs_cnt++;
            if (n < HT * VT && vs) vs_cnt++;
            if (frame_start) fs_cnt++;
            if (n >= 5 * HT && n < 6 * HT && vram_bus.vram_rd) st5++;
            if (n >= VA * HT && n < HT * VT && vram_bus.vram_rd) stv++;

            if (n == 0) begin chk("first_rd", vram_bus.vram_rd, 1); chk("first_addr", vram_bus.vram_addr, 0); end
            if (n == 1) chk("rd_once", vram_bus.vram_rd, 0);
            if (n >= 10 && n <= 17) chk("mono_r", r, pat[17-n] ? 63 : 0);
            if (n == 10) begin chk("mono_g", g, 63); chk("mono_b", b, 63); chk("mono_de", de, 1); end
            if (n == 40) chk("lastcol_r30", r, 0);
            if (n == 41) begin chk("lastcol_r31", r, 63); chk("lastcol_de", de, 1); end
            if (n == 42) begin chk("blank_de", de, 0); chk("blank_r", r, 0); end
            if (n == 49) chk("hs_pre", hs, 0);
            if (n == 50) chk("hs_rise", hs, 1);
            if (n == 57) chk("hs_last", hs, 1);
            if (n == 58) chk("hs_fall", hs, 0);
            if (n == 67) mode = 2'd1;
            if (n == 74 || n == 81) chk("msw_col0", r, 63);
            if (n == 82) begin chk("msw_col1", r, 0); chk("msw_de", de, 1); end
            if (n == 89) chk("msw_col1_end", r, 0);
            if (n == 100) mode = 2'd2;
            if (n == 138 || n == 141) begin
                chk("fg16_fg_r", r, 63); chk("fg16_fg_g", g, 15); chk("fg16_fg_b", b, 15);
            end
            if (n == 142 || n == 145) begin
                chk("fg16_bg_r", r, 15); chk("fg16_bg_g", g, 63); chk("fg16_bg_b", b, 63);
            end
            if (n == 150) mode = 2'd1;
            if (n == 202) begin chk("fg8_r", r, 63); chk("fg8_g", g, 0); chk("fg8_b", b, 63); end
            if (n == 203) chk("fg8_off", r, 0);
            if (n == 210) mode = 2'd3;
            if (n == 266) begin chk("m3_r", r, 63); chk("m3_g", g, 63); chk("m3_b", b, 63); end
            if (n == 267) chk("m3_off", g, 0);
            if (n == 280) mode = 2'd0;
            if (n == 5 * HT + 8) begin
                chk("fetch_rd", vram_bus.vram_rd, 1);
                chk("fetch_addr", vram_bus.vram_addr, {2'd1, 4'd5});
            end
            if (n == HT * VT - 2) chk("fs_early", frame_start, 0);
            if (n == HT * VT - 1) chk("fs_wrap", frame_start, 1);
            if (n == HT * VT) begin chk("wrap_rd", vram_bus.vram_rd, 1); chk("wrap_addr", vram_bus.vram_addr, 0); end
            if (n == HT * VT + 10) chk("wrap_pix", r, 63);
            @(negedge clk_pix);
        end
        chk("hs_width", hs_cnt, HSE - HSS);
        chk("vs_width", vs_cnt, (VSE - VSS) * HT);
        chk("fs_count", fs_cnt, 2);
        chk("strobes_line5", st5, HA / 8);
        chk("strobes_vblank", stv, 0);

        // ce every other clk, then reset mid-frame at vc=5, hc=20.
        reset = 1'b1;
        @(negedge clk_pix);
        @(negedge clk_pix);
        reset = 1'b0;
        tick = 0;
        for (int k = 0; k < 2000 && !(tick == 5 * HT + 20 && ce_pix); k++) begin
            #1;
            if (tick == 0 && ce_pix) begin chk("ce2_rd0", vram_bus.vram_rd, 1); chk("ce2_addr0", vram_bus.vram_addr, 0); end
            if (tick == 8 && !ce_pix) begin chk("ce2_rd_idle", vram_bus.vram_rd, 0); chk("ce2_fs_idle", frame_start, 0); end
            if (tick == 8 && ce_pix) begin chk("ce2_rd8", vram_bus.vram_rd, 1); chk("ce2_addr8", vram_bus.vram_addr, {2'd1, 4'd0}); end
            if (tick >= 10 && tick <= 17) chk("ce2_pix", r, pat[17-tick] ? 63 : 0);
            @(posedge clk_pix);
            if (ce_pix) tick++;
            @(negedge clk_pix);
            ce_pix = !ce_pix;
        end
        #1;
        chk("ce2_reach", tick, 5 * HT + 20);
        chk("pre_rst_de", de, 1);
        chk("pre_rst_r", r, 63);
        reset = 1'b1;
        @(negedge clk_pix);
        ce_pix = 1'b1;
        #1 chk_zero("midrst");
        @(negedge clk_pix);
        reset = 1'b0;
        #1;
        chk("rel_rd", vram_bus.vram_rd, 1);
        chk("rel_addr", vram_bus.vram_addr, 0);
        repeat (10) @(posedge clk_pix);
        @(negedge clk_pix);
        #1;
        chk("rel_pix0", r, 63);
        chk("rel_de", de, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
